clock_div_ctrl: RTL and testbench
=================================

Name: clock_div_ctrl

Overview:
Run/stop/single-step controller for a programmable counter-based clock divider. It owns the divide counter and sequences its output: free-run, clean stop without runt pulses, and single-period step. A valid/ready config port retunes the divisor, and changes take effect only at period boundaries. It produces div_clock plus a one-cycle tick enable for downstream logic in the 100 MHz domain.

Parameters:
WIDTH, 17, bit width of divisor and internal counter
DEFAULT_DIV, 1, half-period in clock cycles loaded at reset (1 = divide-by-2, used for benches)

Ports:
clock  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-high reset
run  input  1  level; 1 = free-run divider
step  input  1  pulse; request one full div_clock period from IDLE
cfg_valid  input  1  new divisor offered
cfg_ready  output  1  controller can accept a divisor
cfg_div  input  WIDTH  requested half-period in clock cycles
div_clock  output  1  divided clock, registered
tick  output  1  one-cycle pulse coincident with each div_clock 0->1 edge
busy  output  1  state != IDLE
active_div  output  WIDTH  half-period currently in force

Behaviour:
- Reset values (async): state IDLE, counter 0, div_clock 0, tick 0, busy 0, active_div = DEFAULT_DIV, no pending config, cfg_ready 1.
- Counter: counts 0..active_div-1 in RUN, STEP and DRAIN.
  - Terminal count is counter == active_div-1.
  - At terminal count: counter <= 0 and div_clock toggles.
  - Output period = 2*active_div clock cycles, 50% duty.
- tick = 1 only in the cycle where div_clock becomes 1 (registered, same edge).
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready; cfg_div is captured into a pending register and cfg_ready drops to 0.
  - cfg_div = 0 is stored as 1.
  - Pending value applies in IDLE on the next cycle.
  - In RUN/STEP/DRAIN it applies at the terminal count where div_clock falls 1->0, so the next low phase uses the new value.
  - cfg_ready returns to 1 in the cycle after application.
  - A transfer in the same cycle as a falling boundary waits for the next falling boundary.
- States:
  - IDLE: counter held 0, div_clock 0.
    - run=1 -> RUN (run has priority over step).
    - step=1 -> STEP.
    - First toggle (to 1) occurs active_div cycles after entry.
  - RUN: free-running.
    - run=0 with div_clock=0 -> IDLE; counter cleared, no high pulse truncated.
    - run=0 with div_clock=1 -> DRAIN.
  - DRAIN: keep counting.
    - Falling toggle -> IDLE.
    - run=1 -> RUN with no counter reset and no glitch.
  - STEP: count through one rise and one fall, then -> IDLE on the falling toggle. step and run are ignored while in STEP.
- div_clock never shows a high phase shorter than active_div cycles, except on reset.
- Reset mid-operation: immediate return to reset values; the pending config is discarded.

Optional Feature:
- Macro: CLOCK_DIV_CTRL_STATUS_EN.
- Defined: adds output period_count [15:0], incremented on every tick. It wraps from 65535 to 0, is cleared only by reset, and resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, DEFAULT_DIV=1, run=1 -> div_clock toggles every cycle (period 2), tick on every second cycle, busy=1, active_div=1.
- IDLE, cfg_div=5 accepted, then run=1 -> active_div=5 one cycle after transfer; first rise 5 cycles after RUN entry; period 10; cfg_ready back to 1.
- RUN at div 3, cfg_div=7 offered mid-high-phase -> current high phase stays 3 cycles; following low phase and later phases are 7; cfg_ready=0 until that falling boundary.
- RUN at div 4, run dropped 1 cycle into high phase -> DRAIN, high phase completes its full 4 cycles, then IDLE, div_clock=0, busy=0; dropping run during low phase -> IDLE next cycle.
- IDLE at div 2, step pulse -> exactly one rise (2 cycles after entry) and one fall (2 cycles later), exactly 1 tick, then IDLE; a second step during STEP is ignored; cfg_div=0 -> active_div=1.
- Async reset asserted in RUN with pending config -> div_clock, tick, busy immediately 0; active_div=DEFAULT_DIV; cfg_ready=1. With STATUS_EN, period_count=0 and it wraps 65535->0.

Source files
------------

// File: rtl/clock_div_ctrl.sv
// ---------------------------------------------------------------------------
// clock_div_ctrl
//   Run/stop/single-step controller for a counter-based clock divider.
//   Owns the divide counter and sequences div_clock through free-run, clean
//   stop (no truncated high phase) and single-period step. A valid/ready
//   config port retunes the half-period; new values only take effect at a
//   falling div_clock boundary (or immediately from IDLE).
//
// Parameters
//   WIDTH        bit width of divisor and internal counter
//   DEFAULT_DIV  half-period (clock cycles) loaded at reset
//
// Ports
//   clock        system clock
//   reset        asynchronous, active-high reset
//   run          level, 1 = free-run the divider
//   step         pulse, request one full div_clock period from IDLE
//   cfg_valid    new half-period offered on cfg_div
//   cfg_ready    controller can accept a half-period
//   cfg_div      requested half-period (0 is treated as 1)
//   div_clock    divided clock, registered
//   tick         one-cycle pulse coincident with each div_clock rise
//   busy         controller is not IDLE
//   active_div   half-period currently in force
//   period_count (only with CLOCK_DIV_CTRL_STATUS_EN) 16-bit tick counter
//
// Optional feature macro: CLOCK_DIV_CTRL_STATUS_EN
// ---------------------------------------------------------------------------
module clock_div_ctrl #(
   parameter int unsigned WIDTH       = 17,
   parameter int unsigned DEFAULT_DIV = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             div_clock,
   output logic             tick,
   output logic             busy,
   output logic [WIDTH-1:0] active_div
`ifdef CLOCK_DIV_CTRL_STATUS_EN
   ,
   output logic [15:0]      period_count
`endif
);

   localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] counter_q, counter_d;
   logic             div_clock_q, div_clock_d;
   logic             tick_q, tick_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] active_div_q, active_div_d;
   logic             pend_valid_q, pend_valid_d;
   logic [WIDTH-1:0] pend_div_q, pend_div_d;
   logic             cfg_ready_q, cfg_ready_d;

   logic             terminal;
   logic             fall;
   logic             apply_cfg;

   // Phase boundary and falling-edge detection on the counter in force.
   always_comb begin
      terminal  = (counter_q == (active_div_q - ONE));
      fall      = (state_q != ST_IDLE) && terminal && div_clock_q;
      apply_cfg = pend_valid_q && ((state_q == ST_IDLE) || fall);
   end

   // Next-state, counter, output and config-handshake logic.
   always_comb begin
      state_d      = state_q;
      counter_d    = counter_q;
      div_clock_d  = div_clock_q;
      tick_d       = 1'b0;
      active_div_d = active_div_q;
      pend_valid_d = pend_valid_q;
      pend_div_d   = pend_div_q;

      // Common counting for every non-IDLE state.
      if (state_q != ST_IDLE) begin
         if (terminal) begin
            counter_d   = '0;
            div_clock_d = ~div_clock_q;
            tick_d      = ~div_clock_q;
         end else begin
            counter_d = counter_q + ONE;
         end
      end

      case (state_q)
         ST_IDLE: begin
            counter_d   = '0;
            div_clock_d = 1'b0;
            if (run) begin
               state_d = ST_RUN;
            end else if (step) begin
               state_d = ST_STEP;
            end
         end
         ST_RUN: begin
            if (!run) begin
               if (!div_clock_q) begin
                  // Stopping in the low phase: drop straight to IDLE and
                  // suppress any rise that would have started this edge.
                  state_d     = ST_IDLE;
                  counter_d   = '0;
                  div_clock_d = 1'b0;
                  tick_d      = 1'b0;
               end else if (fall) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Re-asserting run resumes seamlessly, even on the falling edge.
            if (run) begin
               state_d = ST_RUN;
            end else if (fall) begin
               state_d = ST_IDLE;
            end
         end
         ST_STEP: begin
            if (fall) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Pending divisor moves into force; counter is already 0 here.
      if (apply_cfg) begin
         active_div_d = pend_div_q;
         pend_valid_d = 1'b0;
      end

      // Handshake capture; cfg_ready is low whenever a value is pending,
      // so capture and apply never coincide.
      if (cfg_valid && cfg_ready_q) begin
         pend_valid_d = 1'b1;
         pend_div_d   = (cfg_div == '0) ? ONE : cfg_div;
      end
   end

   always_comb begin
      busy_d      = (state_d != ST_IDLE);
      cfg_ready_d = ~pend_valid_d;
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         counter_q    <= '0;
         div_clock_q  <= 1'b0;
         tick_q       <= 1'b0;
         busy_q       <= 1'b0;
         active_div_q <= RESET_DIV;
         pend_valid_q <= 1'b0;
         pend_div_q   <= RESET_DIV;
         cfg_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         counter_q    <= counter_d;
         div_clock_q  <= div_clock_d;
         tick_q       <= tick_d;
         busy_q       <= busy_d;
         active_div_q <= active_div_d;
         pend_valid_q <= pend_valid_d;
         pend_div_q   <= pend_div_d;
         cfg_ready_q  <= cfg_ready_d;
      end
   end

   assign div_clock  = div_clock_q;
   assign tick       = tick_q;
   assign busy       = busy_q;
   assign active_div = active_div_q;
   assign cfg_ready  = cfg_ready_q;

`ifdef CLOCK_DIV_CTRL_STATUS_EN
   logic [15:0] period_count_q, period_count_d;

   // Counts ticks; updates on the same edge the tick is raised, wraps freely.
   always_comb begin
      period_count_d = period_count_q;
      if (tick_d) begin
         period_count_d = period_count_q + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         period_count_q <= 16'd0;
      end else begin
         period_count_q <= period_count_d;
      end
   end

   assign period_count = period_count_q;
`endif

endmodule

// File: tb/tb_clock_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_div_ctrl
//   Scoreboard bench: a phase-length reference model predicts the outputs
//   after every clock edge and queues them; a negedge monitor pops and
//   compares against the DUT.
// ---------------------------------------------------------------------------
module tb_clock_div_ctrl;

   localparam int unsigned WIDTH       = 17;
   localparam int unsigned DEFAULT_DIV = 1;

   logic             clock = 1'b0;
   logic             reset;
   logic             run;
   logic             step;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_div;
   logic             div_clock;
   logic             tick;
   logic             busy;
   logic [WIDTH-1:0] active_div;
`ifdef CLOCK_DIV_CTRL_STATUS_EN
   logic [15:0]      period_count;
`endif

   clock_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
      .clock      (clock),
      .reset      (reset),
      .run        (run),
      .step       (step),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_div    (cfg_div),
      .div_clock  (div_clock),
      .tick       (tick),
      .busy       (busy),
      .active_div (active_div)
`ifdef CLOCK_DIV_CTRL_STATUS_EN
      ,
      .period_count (period_count)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        lvl;
      logic        tck;
      logic        bsy;
      logic        rdy;
      int unsigned div;
      int unsigned pc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: mode 0 idle, 1 run, 2 step, 3 drain.
   // m_left = cycles remaining in the current div_clock phase.
   int          m_mode;
   bit          m_lvl, m_tick, m_pend;
   int unsigned m_left, m_div, m_pdiv, m_ticks;

   task automatic check(input string name, input int unsigned act, input int unsigned req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
      end
   endtask

   always @(posedge clock) begin : model
      bit   accept, bnd, fall, pre_lvl;
      exp_t e;
      if (reset) begin
         m_mode  = 0;
         m_lvl   = 0;
         m_tick  = 0;
         m_pend  = 0;
         m_left  = 0;
         m_div   = DEFAULT_DIV;
         m_pdiv  = DEFAULT_DIV;
         m_ticks = 0;
      end else begin
         accept  = cfg_valid && !m_pend;
         pre_lvl = m_lvl;
         if (m_mode == 0) begin
            m_tick = 0;
            m_lvl  = 0;
            if (m_pend) begin
               m_div  = m_pdiv;
               m_pend = 0;
            end
            if (run) begin
               m_mode = 1;
               m_left = m_div;
            end else if (step) begin
               m_mode = 2;
               m_left = m_div;
            end
         end else begin
            bnd    = (m_left == 1);
            fall   = bnd && pre_lvl;
            m_tick = bnd && !pre_lvl;
            if (bnd) begin
               m_lvl = !pre_lvl;
               if (fall && m_pend) begin
                  m_div  = m_pdiv;
                  m_pend = 0;
               end
               m_left = m_div;
            end else begin
               m_left = m_left - 1;
            end
            case (m_mode)
               1: if (!run) begin
                     if (!pre_lvl) begin
                        m_mode = 0;
                        m_lvl  = 0;
                        m_tick = 0;
                     end else if (fall) begin
                        m_mode = 0;
                     end else begin
                        m_mode = 3;
                     end
                  end
               3: if (run) m_mode = 1;
                  else if (fall) m_mode = 0;
               2: if (fall) m_mode = 0;
               default: ;
            endcase
         end
         if (accept) begin
            m_pend = 1;
            m_pdiv = (cfg_div == 0) ? 1 : int'(cfg_div);
         end
         if (m_tick) m_ticks = (m_ticks + 1) % 65536;
      end
      e.lvl = m_lvl;
      e.tck = m_tick;
      e.bsy = (m_mode != 0);
      e.rdy = !m_pend;
      e.div = m_div;
      e.pc  = m_ticks;
      exp_q.push_back(e);
   end

   // Monitor: compare DUT outputs mid-cycle against the oldest prediction.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("div_clock", int'(div_clock), int'(e.lvl));
         check("tick", int'(tick), int'(e.tck));
         check("busy", int'(busy), int'(e.bsy));
         check("cfg_ready", int'(cfg_ready), int'(e.rdy));
         check("active_div", int'(active_div), e.div);
`ifdef CLOCK_DIV_CTRL_STATUS_EN
         check("period_count", int'(period_count), e.pc);
`endif
      end
   end

   // Advance n cycles, leaving inputs changeable 2 time units after the edge.
   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic offer(input int unsigned d);
      cfg_div   = WIDTH'(d);
      cfg_valid = 1'b1;
      cyc(1);
      cfg_valid = 1'b0;
   endtask

   initial begin
      int waited;
      reset     = 1'b1;
      run       = 1'b0;
      step      = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = '0;
      cyc(3);
      reset = 1'b0;
      cyc(2);

      // Divide-by-2 free run from reset.
      run = 1'b1;
      cyc(8);
      run = 1'b0;
      cyc(4);

      // New divisor from IDLE, then run.
      offer(5);
      cyc(2);
      run = 1'b1;
      cyc(30);
      run = 1'b0;
      cyc(14);

      // Retune mid-high-phase at div 3 -> 7.
      offer(3);
      cyc(2);
      run = 1'b1;
      waited = 0;
      while (!div_clock && waited < 50) begin
         cyc(1);
         waited++;
      end
      check("wait_high_div3", int'(div_clock), 1);
      offer(7);
      cyc(40);
      run = 1'b0;
      cyc(20);

      // Div 4: drop run 1 cycle into the high phase, then in the low phase.
      offer(4);
      cyc(2);
      run = 1'b1;
      waited = 0;
      while (!div_clock && waited < 50) begin
         cyc(1);
         waited++;
      end
      check("wait_high_div4", int'(div_clock), 1);
      cyc(1);
      run = 1'b0;
      cyc(10);
      run = 1'b1;
      cyc(2);
      run = 1'b0;
      cyc(6);

      // Single step at div 2 with a second step ignored, then cfg_div = 0.
      offer(2);
      cyc(2);
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      cyc(1);
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      cyc(8);
      offer(0);
      cyc(3);

      // Randomized run/step/config traffic.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) run = ~run;
         step      = ($urandom_range(0, 19) == 0);
         cfg_valid = ($urandom_range(0, 7) == 0);
         cfg_div   = WIDTH'($urandom_range(0, 5));
         cyc(1);
      end
      step      = 1'b0;
      cfg_valid = 1'b0;

      // Async reset while running with a pending config.
      offer(4);
      cyc(2);
      run = 1'b1;
      cyc(11);
      offer(6);
      cyc(1);
      @(posedge clock);
      #5;
      reset = 1'b1;
      #1;
      check("rst_div_clock", int'(div_clock), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_active_div", int'(active_div), DEFAULT_DIV);
      check("rst_cfg_ready", int'(cfg_ready), 1);
`ifdef CLOCK_DIV_CTRL_STATUS_EN
      check("rst_period_count", int'(period_count), 0);
`endif
      cyc(2);
      reset = 1'b0;
      cyc(10);
      run = 1'b0;
      cyc(6);

      @(negedge clock);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
